// File: rtl/calc_entry_ctrl_if.sv
// Keypad-scanner and ALU signal bundle seen by the calculator entry controller.
interface calc_entry_ctrl_if #(
    parameter int unsigned WIDTH = 16
);
    logic             KeyRdy;
    logic             KeyRd;
    logic [3:0]       keypad_input;
    logic [2:0]       operator_input;
    logic             equal_input;
    logic [2:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_start;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_ovf;
    logic [WIDTH-1:0] display_value;
    logic             error;

    // Controller side
    modport master (
        input  KeyRdy, keypad_input, operator_input, equal_input,
        input  alu_done, alu_result, alu_ovf,
        output KeyRd, alu_op, alu_a, alu_b, alu_start, display_value, error
    );

    // Scanner / ALU / display side
    modport slave (
        output KeyRdy, keypad_input, operator_input, equal_input,
        output alu_done, alu_result, alu_ovf,
        input  KeyRd, alu_op, alu_a, alu_b, alu_start, display_value, error
    );
endinterface

// File: rtl/calc_entry_ctrl.sv
// Calculator entry controller: builds signed decimal operands from key
// presses, issues one ALU operation per '=' and holds the result for display
// and chaining.
module calc_entry_ctrl #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned MAX_MAG = 32767
) (
    input  logic                 clk,
    input  logic                 nRST,
    calc_entry_ctrl_if.master    bus
);
    localparam int unsigned MAG_W  = WIDTH - 1;
    localparam int unsigned PROD_W = MAG_W + 4;

    localparam logic [2:0] OP_NEG = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;

    typedef enum logic [2:0] {
        ENTER_A  = 3'd0,
        ENTER_B  = 3'd1,
        ISSUE    = 3'd2,
        WAIT_RES = 3'd3,
        SHOW_RES = 3'd4
    } main_state_t;

    typedef enum logic [1:0] {
        K_WAIT = 2'd0,
        K_ACK  = 2'd1,
        K_REL  = 2'd2
    } key_state_t;

    main_state_t      main_q, main_d;
    key_state_t       key_q, key_d;
    logic [MAG_W-1:0] mag_q, mag_d;
    logic             sign_q, sign_d;
    logic             has_dig_q, has_dig_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] disp_q, disp_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;
    logic             start_q, start_d;
    logic             keyrd_q, keyrd_d;

    logic              key_fire;
    logic              is_digit, is_eq, is_neg, is_arith, is_ce;
    logic [PROD_W-1:0] dig_sum;
    logic              dig_ok;
    logic [WIDTH-1:0]  mag_ext, entry_val;
    logic [WIDTH-1:0]  mag_ext_d, entry_val_d;

    // Key decode with digit > equal > operator > clear-entry priority
    assign is_digit = (bus.keypad_input <= 4'd9);
    assign is_eq    = !is_digit && bus.equal_input;
    assign is_neg   = !is_digit && !bus.equal_input && (bus.operator_input == OP_NEG);
    assign is_arith = !is_digit && !bus.equal_input &&
                      (bus.operator_input inside {OP_ADD, OP_SUB, OP_MUL});
    assign is_ce    = !is_digit && !bus.equal_input && (bus.operator_input == 3'b000);

    // A key is consumed only while the main FSM can act on it
    assign key_fire = (key_q == K_WAIT) && bus.KeyRdy &&
                      (main_q inside {ENTER_A, ENTER_B, SHOW_RES});

    // Candidate magnitude after appending a digit, wide enough not to wrap
    assign dig_sum = PROD_W'(mag_q) * PROD_W'(10) + PROD_W'(bus.keypad_input);
    assign dig_ok  = (dig_sum <= PROD_W'(MAX_MAG));

    // Signed value of the current entry
    assign mag_ext   = WIDTH'(mag_q);
    assign entry_val = sign_q ? -mag_ext : mag_ext;

    // State and datapath registers
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            main_q    <= ENTER_A;
            key_q     <= K_WAIT;
            mag_q     <= '0;
            sign_q    <= 1'b0;
            has_dig_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            disp_q    <= '0;
            op_q      <= 3'b000;
            err_q     <= 1'b0;
            start_q   <= 1'b0;
            keyrd_q   <= 1'b0;
        end else begin
            main_q    <= main_d;
            key_q     <= key_d;
            mag_q     <= mag_d;
            sign_q    <= sign_d;
            has_dig_q <= has_dig_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            disp_q    <= disp_d;
            op_q      <= op_d;
            err_q     <= err_d;
            start_q   <= start_d;
            keyrd_q   <= keyrd_d;
        end
    end

    // Key handshake: one-cycle acknowledge, then wait for key release
    always_comb begin
        key_d   = key_q;
        keyrd_d = 1'b0;
        case (key_q)
            K_WAIT: begin
                if (key_fire) begin
                    keyrd_d = 1'b1;
                    key_d   = K_ACK;
                end
            end
            K_ACK:   key_d = K_REL;
            K_REL:   if (!bus.KeyRdy) key_d = K_WAIT;
            default: key_d = K_WAIT;
        endcase
    end

    // Main sequencing: entry editing, operand latching, ALU issue and result
    always_comb begin
        main_d    = main_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        has_dig_d = has_dig_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        op_d      = op_q;
        err_d     = err_q;
        disp_d    = disp_q;

        case (main_q)
            ENTER_A, ENTER_B: begin
                if (key_fire) begin
                    if (main_q == ENTER_A) err_d = 1'b0;
                    if (is_digit) begin
                        if (dig_ok) begin
                            mag_d     = MAG_W'(dig_sum);
                            has_dig_d = 1'b1;
                        end
                    end else if (is_eq) begin
                        if (main_q == ENTER_B && has_dig_q) begin
                            b_d    = entry_val;
                            main_d = ISSUE;
                        end
                    end else if (is_neg) begin
                        sign_d = ~sign_q;
                    end else if (is_arith) begin
                        if (main_q == ENTER_A) begin
                            a_d       = entry_val;
                            op_d      = bus.operator_input;
                            mag_d     = '0;
                            sign_d    = 1'b0;
                            has_dig_d = 1'b0;
                            main_d    = ENTER_B;
                        end else if (!has_dig_q) begin
                            op_d = bus.operator_input;
                        end
                    end else if (is_ce) begin
                        mag_d     = '0;
                        sign_d    = 1'b0;
                        has_dig_d = 1'b0;
                    end
                end
            end
            ISSUE: main_d = WAIT_RES;
            WAIT_RES: begin
                if (bus.alu_done) begin
                    if (bus.alu_ovf) begin
                        res_d = '0;
                        err_d = 1'b1;
                    end else begin
                        res_d = bus.alu_result;
                    end
                    main_d = SHOW_RES;
                end
            end
            SHOW_RES: begin
                if (key_fire) begin
                    if (is_digit) begin
                        mag_d     = MAG_W'(bus.keypad_input);
                        sign_d    = 1'b0;
                        has_dig_d = 1'b1;
                        err_d     = 1'b0;
                        main_d    = ENTER_A;
                    end else if (is_eq) begin
                        a_d    = res_q;
                        main_d = ISSUE;
                    end else if (is_neg) begin
                        res_d = -res_q;
                    end else if (is_arith) begin
                        a_d       = res_q;
                        op_d      = bus.operator_input;
                        mag_d     = '0;
                        sign_d    = 1'b0;
                        has_dig_d = 1'b0;
                        main_d    = ENTER_B;
                    end else if (is_ce) begin
                        mag_d     = '0;
                        sign_d    = 1'b0;
                        has_dig_d = 1'b0;
                        main_d    = ENTER_A;
                    end
                end
            end
            default: main_d = ENTER_A;
        endcase

        // Display follows the state being entered, on the same edge
        mag_ext_d   = WIDTH'(mag_d);
        entry_val_d = sign_d ? -mag_ext_d : mag_ext_d;
        case (main_d)
            ENTER_A:  disp_d = entry_val_d;
            ENTER_B:  disp_d = has_dig_d ? entry_val_d : a_d;
            SHOW_RES: disp_d = res_d;
            default:  disp_d = disp_q;
        endcase

        start_d = (main_d == ISSUE);
    end

    assign bus.KeyRd         = keyrd_q;
    assign bus.alu_start     = start_q;
    assign bus.alu_op        = op_q;
    assign bus.alu_a         = a_q;
    assign bus.alu_b         = b_q;
    assign bus.display_value = disp_q;
    assign bus.error         = err_q;
endmodule

// File: tb/tb_calc_entry_ctrl.sv
// Scoreboard bench for calc_entry_ctrl: a behavioural calculator model queues
// the expected display/error after each key and the expected ALU request;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_calc_entry_ctrl;
    localparam int S_A = 0, S_B = 1, S_ISS = 2, S_WAIT = 3, S_SHOW = 4;
    localparam int K_DIG = 0, K_EQ = 1, K_OP = 2, K_CE = 3;

    typedef struct packed { logic [15:0] disp; logic err; } kexp_t;
    typedef struct packed { logic [2:0] op; logic [15:0] a; logic [15:0] b; } sexp_t;

    logic clk = 1'b0;
    logic nRST = 1'b0;
    always #5 clk = ~clk;

    calc_entry_ctrl_if #(.WIDTH(16)) bus ();
    calc_entry_ctrl #(.WIDTH(16), .MAX_MAG(32767)) dut (.clk(clk), .nRST(nRST), .bus(bus));

    int checks = 0;
    int errors = 0;
    kexp_t key_q[$];
    kexp_t res_q[$];
    sexp_t start_q[$];
    int rd_cnt = 0;
    int starts_seen = 0;
    int starts_exp = 0;

    // Behavioural calculator model
    int  st, e_mag, m_a, m_b, m_op, m_res, m_disp;
    bit  e_sign, e_has, m_err;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int wrap16(input int x);
        logic signed [15:0] t;
        t = x[15:0];
        return int'(t);
    endfunction

    function automatic int ent();
        return e_sign ? -e_mag : e_mag;
    endfunction

    task automatic model_reset();
        st = S_A; e_mag = 0; e_sign = 0; e_has = 0;
        m_a = 0; m_b = 0; m_op = 0; m_res = 0; m_disp = 0; m_err = 0;
    endtask

    task automatic clear_entry();
        e_mag = 0; e_sign = 0; e_has = 0;
    endtask

    task automatic push_start();
        sexp_t s;
        s.op = 3'(m_op); s.a = 16'(m_a); s.b = 16'(m_b);
        start_q.push_back(s);
        starts_exp++;
    endtask

    // Apply one acknowledged key to the model and queue the expected display
    task automatic model_key(input int kind, input int d, input int opc);
        kexp_t e;
        bit arith;
        arith = (kind == K_OP) && (opc >= 2);
        if (st == S_A || st == S_B) begin
            if (st == S_A) m_err = 0;
            if (kind == K_DIG) begin
                if (e_mag * 10 + d <= 32767) begin e_mag = e_mag * 10 + d; e_has = 1; end
            end else if (kind == K_EQ) begin
                if (st == S_B && e_has) begin m_b = ent(); st = S_ISS; push_start(); end
            end else if (kind == K_OP && opc == 1) begin
                e_sign = !e_sign;
            end else if (arith) begin
                if (st == S_A) begin m_a = ent(); m_op = opc; clear_entry(); st = S_B; end
                else if (!e_has) m_op = opc;
            end else begin
                clear_entry();
            end
        end else if (st == S_SHOW) begin
            if (kind == K_DIG) begin
                clear_entry(); e_mag = d; e_has = 1; m_err = 0; st = S_A;
            end else if (kind == K_EQ) begin
                m_a = m_res; st = S_ISS; push_start();
            end else if (kind == K_OP && opc == 1) begin
                m_res = wrap16(-m_res);
            end else if (arith) begin
                m_a = m_res; m_op = opc; clear_entry(); st = S_B;
            end else begin
                clear_entry(); st = S_A;
            end
        end
        if (st == S_A) m_disp = ent();
        else if (st == S_B) m_disp = e_has ? ent() : m_a;
        else if (st == S_SHOW) m_disp = m_res;
        e.disp = 16'(m_disp); e.err = m_err;
        key_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_key(input int kind, input int d, input int opc);
        if (kind == K_DIG) begin
            bus.keypad_input   = 4'(d);
            bus.equal_input    = 1'($urandom_range(0, 1));
            bus.operator_input = 3'($urandom_range(0, 4));
        end else begin
            bus.keypad_input   = 4'($urandom_range(10, 15));
            bus.equal_input    = (kind == K_EQ);
            bus.operator_input = (kind == K_EQ) ? 3'($urandom_range(0, 4)) :
                                 (kind == K_OP) ? 3'(opc) : 3'b000;
        end
    endtask

    task automatic press(input int kind, input int d, input int opc);
        int r0;
        r0 = rd_cnt;
        set_key(kind, d, opc);
        model_key(kind, d, opc);
        bus.KeyRdy = 1'b1;
        repeat (5) tick();
        bus.KeyRdy = 1'b0;
        repeat (3) tick();
        chk("keyrd_pulses", 32'(rd_cnt - r0), 32'd1);
    endtask

    task automatic dig(input int d); press(K_DIG, d, 0); endtask
    task automatic opk(input int c); press(K_OP, 0, c); endtask
    task automatic eqk();            press(K_EQ, 0, 0); endtask
    task automatic ce();             press(K_CE, 0, 0); endtask

    task automatic wait_start();
        int n;
        n = 0;
        while (starts_seen < starts_exp && n < 40) begin tick(); n++; end
        chk("alu_start_seen", 32'(starts_seen >= starts_exp), 32'd1);
    endtask

    // Behave as the ALU for the pending request
    task automatic alu_respond();
        int r;
        bit ovf;
        kexp_t e;
        wait_start();
        st = S_WAIT;
        repeat ($urandom_range(0, 3)) tick();
        case (m_op)
            2:       r = m_a + m_b;
            3:       r = m_a - m_b;
            default: r = m_a * m_b;
        endcase
        ovf = (r > 32767) || (r < -32768);
        m_res = ovf ? 0 : r;
        if (ovf) m_err = 1;
        st = S_SHOW;
        m_disp = m_res;
        e.disp = 16'(m_disp); e.err = m_err;
        res_q.push_back(e);
        bus.alu_result = 16'(r);
        bus.alu_ovf    = ovf;
        bus.alu_done   = 1'b1;
        tick();
        bus.alu_done   = 1'b0;
        bus.alu_ovf    = 1'b0;
        bus.alu_result = 16'($urandom);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_keyrd"}, 32'(bus.KeyRd), 32'd0);
        chk({tag, "_start"}, 32'(bus.alu_start), 32'd0);
        chk({tag, "_op"},    32'(bus.alu_op), 32'd0);
        chk({tag, "_a"},     32'(bus.alu_a), 32'd0);
        chk({tag, "_b"},     32'(bus.alu_b), 32'd0);
        chk({tag, "_disp"},  32'(bus.display_value), 32'd0);
        chk({tag, "_err"},   32'(bus.error), 32'd0);
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations
    initial begin
        bit done_prev;
        bit rd_prev;
        kexp_t k;
        sexp_t s;
        done_prev = 0;
        rd_prev   = 0;
        forever begin
            @(negedge clk);
            if (!nRST) begin
                done_prev = 0;
                rd_prev   = 0;
            end else begin
                if (done_prev && res_q.size() > 0) begin
                    k = res_q.pop_front();
                    chk("result_display", 32'(bus.display_value), 32'(k.disp));
                    chk("result_error", 32'(bus.error), 32'(k.err));
                end
                if (bus.KeyRd) begin
                    rd_cnt++;
                    chk("keyrd_width", 32'(rd_prev), 32'd0);
                    if (key_q.size() == 0) begin
                        chk("key_ack_expected", 32'd1, 32'd0);
                    end else begin
                        k = key_q.pop_front();
                        chk("key_display", 32'(bus.display_value), 32'(k.disp));
                        chk("key_error", 32'(bus.error), 32'(k.err));
                    end
                end
                if (bus.alu_start) begin
                    starts_seen++;
                    if (start_q.size() == 0) begin
                        chk("alu_start_expected", 32'd1, 32'd0);
                    end else begin
                        s = start_q.pop_front();
                        chk("alu_op", 32'(bus.alu_op), 32'(s.op));
                        chk("alu_a", 32'(bus.alu_a), 32'(s.a));
                        chk("alu_b", 32'(bus.alu_b), 32'(s.b));
                    end
                end
                done_prev = bus.alu_done;
                rd_prev   = bus.KeyRd;
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, kind, v;
        bus.KeyRdy = 0; bus.keypad_input = 4'hF; bus.operator_input = 3'b000;
        bus.equal_input = 0; bus.alu_done = 0; bus.alu_result = '0; bus.alu_ovf = 0;
        model_reset();
        repeat (3) tick();
        chk_all_zero("reset");
        nRST = 1'b1;
        repeat (2) tick();

        // 1,2,3 -> 123
        dig(1); dig(2); dig(3);
        chk("disp_123", 32'(bus.display_value), 32'd123);

        // 12 + 7 = 19
        ce(); dig(1); dig(2); opk(2); dig(7); eqk();
        alu_respond();
        tick();
        chk("add_a", 32'(bus.alu_a), 32'd12);
        chk("add_b", 32'(bus.alu_b), 32'd7);
        chk("add_op", 32'(bus.alu_op), 32'd2);
        chk("add_disp", 32'(bus.display_value), 32'd19);

        // 32768 rejected
        dig(3); dig(2); dig(7); dig(6); dig(8);
        chk("disp_3276", 32'(bus.display_value), 32'd3276);

        // -5 * 4, then result - 3
        ce(); dig(5); opk(1); opk(4); dig(4); eqk();
        alu_respond();
        tick();
        chk("mul_a", 32'(bus.alu_a), 32'h0000_FFFB);
        chk("mul_b", 32'(bus.alu_b), 32'd4);
        chk("mul_op", 32'(bus.alu_op), 32'd4);
        chk("mul_disp", 32'(bus.display_value), 32'h0000_FFEC);
        opk(3); dig(3); eqk();
        alu_respond();
        tick();
        chk("sub_a", 32'(bus.alu_a), 32'h0000_FFEC);
        chk("sub_b", 32'(bus.alu_b), 32'd3);
        chk("sub_op", 32'(bus.alu_op), 32'd3);
        chk("sub_disp", 32'(bus.display_value), 32'h0000_FFE9);

        // Key held through WAIT_RES is stalled; 300*200 overflows
        ce(); dig(3); dig(0); dig(0); opk(4); dig(2); dig(0); dig(0); eqk();
        r0 = rd_cnt;
        set_key(K_OP, 0, 1);
        bus.KeyRdy = 1'b1;
        repeat (10) tick();
        chk("stall_no_keyrd", 32'(rd_cnt - r0), 32'd0);
        alu_respond();
        model_key(K_OP, 0, 1);
        repeat (3) tick();
        bus.KeyRdy = 1'b0;
        repeat (3) tick();
        chk("stall_ack_once", 32'(rd_cnt - r0), 32'd1);
        chk("ovf_error", 32'(bus.error), 32'd1);
        chk("ovf_disp", 32'(bus.display_value), 32'd0);
        dig(7);
        chk("err_cleared", 32'(bus.error), 32'd0);

        // Reset in WAIT_RES; stale done afterwards is ignored
        ce(); dig(5); opk(2); dig(6); eqk();
        wait_start();
        nRST = 1'b0;
        #1;
        chk_all_zero("midreset");
        model_reset();
        repeat (2) tick();
        nRST = 1'b1;
        tick();
        bus.alu_result = 16'd77; bus.alu_done = 1'b1;
        tick();
        bus.alu_done = 1'b0;
        repeat (2) tick();
        chk("stale_done_disp", 32'(bus.display_value), 32'd0);
        chk("stale_done_err", 32'(bus.error), 32'd0);
        dig(4);
        chk("after_reset_disp", 32'(bus.display_value), 32'd4);

        // Randomised key stream
        for (int i = 0; i < 200; i++) begin
            v = int'($urandom_range(0, 9));
            if (v <= 4)      kind = K_DIG;
            else if (v <= 6) kind = K_OP;
            else if (v <= 8) kind = K_EQ;
            else             kind = K_CE;
            press(kind, int'($urandom_range(0, 9)), int'($urandom_range(1, 4)));
            if (st == S_ISS) alu_respond();
        end
        repeat (4) tick();

        chk("key_queue_empty", 32'(key_q.size()), 32'd0);
        chk("res_queue_empty", 32'(res_q.size()), 32'd0);
        chk("start_queue_empty", 32'(start_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
